// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and the controller state encoding for rf_ctrl.
//   XLEN_DEF  - default data width
//   DEPTH_DEF - default register address width (2**DEPTH_DEF entries)
//   state_t   - controller state (CLEAR sweep, RUN normal operation)
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int DEPTH_DEF = 5;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/sync_sram.sv
// sync_sram: 2**AW x XLEN storage array, one write port and two read ports,
// all synchronous to clk. Read data registers only update when their read
// enable is high, so they hold the last word read otherwise. A read and a
// write to the same address in one cycle return the old word; rf_ctrl
// supplies the bypass.
//   clk            - clock
//   we/waddr/wdata - write port
//   re1/raddr1     - read port 1 request, rdata1 valid next cycle
//   re2/raddr2     - read port 2 request, rdata2 valid next cycle
module sync_sram
    import rf_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AW   = DEPTH_DEF
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic            re1,
    input  logic [AW-1:0]   raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic            re2,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re1) begin
            rdata1 <= mem[raddr1];
        end
        if (re2) begin
            rdata2 <= mem[raddr2];
        end
    end

endmodule

// File: rtl/rf_ctrl.sv
// rf_ctrl: register-file controller around one sync_sram. After reset it
// sweeps zeros into entries 1..2**depth-1, then serves two core read ports,
// a writeback port and a debug port. Entry 0 always reads as zero.
//   clk, rst_n                 - clock, async active-low reset
//   rf_ready                   - sweep finished, core may issue accesses
//   rs1_en/rs1_addr/rs1_data   - core read port 1 (data one cycle later)
//   rs2_en/rs2_addr/rs2_data   - core read port 2 (shared with debug reads)
//   wb_we/wb_addr/wb_data      - writeback port (priority over debug write)
//   dbg_req/dbg_we/dbg_addr/dbg_wdata/dbg_ready - debug request handshake
//   dbg_rvalid/dbg_rdata       - debug read response, one cycle after accept
//
// state | meaning
// ------+----------------------------------------------------------------
// CLEAR | sweep writes 0 to entry sweep_cnt each cycle; all requests ignored
// RUN   | normal operation, rf_ready=1
module rf_ctrl
    import rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int depth = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             rf_ready,
    input  logic             rs1_en,
    input  logic [depth-1:0] rs1_addr,
    output logic [XLEN-1:0]  rs1_data,
    input  logic             rs2_en,
    input  logic [depth-1:0] rs2_addr,
    output logic [XLEN-1:0]  rs2_data,
    input  logic             wb_we,
    input  logic [depth-1:0] wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             dbg_req,
    input  logic             dbg_we,
    input  logic [depth-1:0] dbg_addr,
    input  logic [XLEN-1:0]  dbg_wdata,
    output logic             dbg_ready,
    output logic             dbg_rvalid,
    output logic [XLEN-1:0]  dbg_rdata
);

    state_t           state;
    logic [depth-1:0] sweep_cnt;
    logic             run;

    logic             dbg_wr_acc;
    logic             dbg_rd_acc;

    logic             mem_we;
    logic [depth-1:0] mem_waddr;
    logic [XLEN-1:0]  mem_wdata;

    logic             rd1_issue;
    logic             rd2_rs;
    logic             rd2_issue;
    logic [depth-1:0] rd2_addr;
    logic             hit1;
    logic             hit2;

    logic [XLEN-1:0]  sram_rd1;
    logic [XLEN-1:0]  sram_rd2;

    // Per read port: what the last read resolved to (zero / bypass / SRAM).
    logic             p1_zero, p1_byp;
    logic [XLEN-1:0]  p1_byp_data;
    logic             p2_zero, p2_byp;
    logic [XLEN-1:0]  p2_byp_data;
    logic [XLEN-1:0]  p1_val;
    logic [XLEN-1:0]  p2_val;

    // Port 2 is shared: rs2_live says its registers still belong to rs2.
    // Once a debug read takes the port, rs2_hold keeps the last rs2 value.
    logic             rs1_live;
    logic             rs2_live;
    logic [XLEN-1:0]  rs2_hold;
    logic [XLEN-1:0]  dbg_hold;

    assign run = (state == RUN);

    assign dbg_wr_acc = run & dbg_req &  dbg_we & ~wb_we;
    assign dbg_rd_acc = run & dbg_req & ~dbg_we & ~rs2_en;
    assign dbg_ready  = dbg_wr_acc | dbg_rd_acc;

    // Write port: sweep in CLEAR, writeback first in RUN, then debug.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = sweep_cnt;
        mem_wdata = '0;
        if (!run) begin
            mem_we = 1'b1;
        end else if (wb_we) begin
            mem_we    = (wb_addr != '0);
            mem_waddr = wb_addr;
            mem_wdata = wb_data;
        end else if (dbg_wr_acc) begin
            mem_we    = (dbg_addr != '0);
            mem_waddr = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    assign rd1_issue = run & rs1_en;
    assign rd2_rs    = run & rs2_en;
    assign rd2_issue = rd2_rs | dbg_rd_acc;
    assign rd2_addr  = rs2_en ? rs2_addr : dbg_addr;

    // mem_we is never set for entry 0 in RUN, so no hit on address 0.
    assign hit1 = run & mem_we & (mem_waddr == rs1_addr);
    assign hit2 = run & mem_we & (mem_waddr == rd2_addr);

    sync_sram #(
        .XLEN (XLEN),
        .AW   (depth)
    ) u_sram (
        .clk    (clk),
        .we     (mem_we),
        .waddr  (mem_waddr),
        .wdata  (mem_wdata),
        .re1    (rd1_issue),
        .raddr1 (rs1_addr),
        .rdata1 (sram_rd1),
        .re2    (rd2_issue),
        .raddr2 (rd2_addr),
        .rdata2 (sram_rd2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            sweep_cnt <= depth'(1);
            rf_ready  <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (sweep_cnt == '1) begin
                        state    <= RUN;
                        rf_ready <= 1'b1;
                    end
                end
                RUN: begin
                    rf_ready <= 1'b1;
                end
                default: begin
                    state    <= CLEAR;
                    rf_ready <= 1'b0;
                end
            endcase
        end
    end

    assign p1_val = p1_zero ? '0 : (p1_byp ? p1_byp_data : sram_rd1);
    assign p2_val = p2_zero ? '0 : (p2_byp ? p2_byp_data : sram_rd2);

    // The SRAM read registers have no reset; until the first read after
    // reset the outputs show the (reset) hold values instead.
    assign rs1_data  = rs1_live   ? p1_val : '0;
    assign rs2_data  = rs2_live   ? p2_val : rs2_hold;
    assign dbg_rdata = dbg_rvalid ? p2_val : dbg_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_zero     <= 1'b0;
            p1_byp      <= 1'b0;
            p1_byp_data <= '0;
            p2_zero     <= 1'b0;
            p2_byp      <= 1'b0;
            p2_byp_data <= '0;
            rs1_live    <= 1'b0;
            rs2_live    <= 1'b0;
            rs2_hold    <= '0;
            dbg_hold    <= '0;
            dbg_rvalid  <= 1'b0;
        end else begin
            if (rd1_issue) begin
                p1_zero     <= (rs1_addr == '0);
                p1_byp      <= hit1;
                p1_byp_data <= mem_wdata;
                rs1_live    <= 1'b1;
            end
            if (rd2_issue) begin
                p2_zero     <= (rd2_addr == '0);
                p2_byp      <= hit2;
                p2_byp_data <= mem_wdata;
            end
            if (rd2_rs) begin
                rs2_live <= 1'b1;
            end else if (dbg_rd_acc) begin
                rs2_live <= 1'b0;
                if (rs2_live) begin
                    rs2_hold <= p2_val;
                end
            end
            if (dbg_rvalid) begin
                dbg_hold <= p2_val;
            end
            dbg_rvalid <= dbg_rd_acc;
        end
    end

endmodule

// File: tb/tb_rf_ctrl.sv
module tb_rf_ctrl;

    localparam int XLEN = 32;
    localparam int D    = 5;
    localparam int N    = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            rf_ready;
    logic            rs1_en, rs2_en, wb_we, dbg_req, dbg_we;
    logic [D-1:0]    rs1_addr, rs2_addr, wb_addr, dbg_addr;
    logic [XLEN-1:0] rs1_data, rs2_data, wb_data, dbg_wdata, dbg_rdata;
    logic            dbg_ready, dbg_rvalid;

    always #5 clk = ~clk;

    rf_ctrl #(.XLEN(XLEN), .depth(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rf_ready   (rf_ready),
        .rs1_en     (rs1_en),
        .rs1_addr   (rs1_addr),
        .rs1_data   (rs1_data),
        .rs2_en     (rs2_en),
        .rs2_addr   (rs2_addr),
        .rs2_data   (rs2_data),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_ready  (dbg_ready),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata)
    );

    typedef struct {
        int unsigned due;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        rdy;
    } cyc_exp_t;

    typedef struct {
        int unsigned due;
        logic [31:0] val;
    } dbg_exp_t;

    cyc_exp_t    q_cyc[$];
    dbg_exp_t    q_dbg[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    // Reference model: architectural register contents and last read results.
    logic [31:0] m_mem [N];
    int          clr_left;
    logic [31:0] m_rs1, m_rs2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rd(input logic [4:0] a, input logic w,
                                       input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (w && wa == a) return wd;
        return m_mem[a];
    endfunction

    // Monitor: pops expectations as the DUT presents results.
    initial begin
        cyc_exp_t e;
        dbg_exp_t d;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n) begin
                if (q_cyc.size() > 0 && q_cyc[0].due == cyc) begin
                    e = q_cyc.pop_front();
                    chk("rs1_data", rs1_data, e.rs1);
                    chk("rs2_data", rs2_data, e.rs2);
                    chk("rf_ready", {31'd0, rf_ready}, {31'd0, e.rdy});
                end
                if (dbg_rvalid === 1'b1) begin
                    if (q_dbg.size() > 0 && q_dbg[0].due == cyc) begin
                        d = q_dbg.pop_front();
                        chk("dbg_rdata", dbg_rdata, d.val);
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL dbg_rvalid: got 1 expected 0 (cycle %0d)", cyc);
                    end
                end else if (q_dbg.size() > 0 && q_dbg[0].due == cyc) begin
                    void'(q_dbg.pop_front());
                    checks++;
                    errors++;
                    $display("FAIL dbg_rvalid: got %b expected 1 (cycle %0d)", dbg_rvalid, cyc);
                end
            end
        end
    end

    task automatic drive_idle();
        rs1_en = 0; rs1_addr = '0; rs2_en = 0; rs2_addr = '0;
        wb_we = 0; wb_addr = '0; wb_data = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    // One clock cycle: called at a negedge, returns at the next negedge.
    task automatic step(input logic r1en, input logic [4:0] r1a,
                        input logic r2en, input logic [4:0] r2a,
                        input logic wbwe, input logic [4:0] wba, input logic [31:0] wbd,
                        input logic dreq, input logic dwe, input logic [4:0] da,
                        input logic [31:0] dwd, output logic acc);
        logic        run, exp_rdy, w;
        logic [4:0]  wa;
        logic [31:0] wd;
        rs1_en = r1en; rs1_addr = r1a; rs2_en = r2en; rs2_addr = r2a;
        wb_we = wbwe; wb_addr = wba; wb_data = wbd;
        dbg_req = dreq; dbg_we = dwe; dbg_addr = da; dbg_wdata = dwd;
        #1;
        run     = (clr_left == 0);
        exp_rdy = run && dreq && (dwe ? !wbwe : !r2en);
        chk("dbg_ready", {31'd0, dbg_ready}, {31'd0, exp_rdy});
        acc = exp_rdy;
        w = 0; wa = '0; wd = '0;
        if (run && wbwe) begin
            w = 1; wa = wba; wd = wbd;
        end else if (exp_rdy && dwe) begin
            w = 1; wa = da; wd = dwd;
        end
        if (run && r1en) m_rs1 = rd(r1a, w, wa, wd);
        if (run && r2en) m_rs2 = rd(r2a, w, wa, wd);
        if (exp_rdy && !dwe) q_dbg.push_back('{due: cyc + 1, val: rd(da, w, wa, wd)});
        if (w && wa != 5'd0) m_mem[wa] = wd;
        if (clr_left > 0) clr_left--;
        q_cyc.push_back('{due: cyc + 1, rs1: m_rs1, rs2: m_rs2, rdy: (clr_left == 0)});
        @(negedge clk);
    endtask

    task automatic idle();
        logic a;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a);
    endtask

    // Called at a negedge; releases reset at a later negedge.
    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        drive_idle();
        q_cyc.delete();
        q_dbg.delete();
        #1;
        chk("reset rf_ready",   {31'd0, rf_ready},   32'd0);
        chk("reset dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
        chk("reset rs1_data",   rs1_data,  32'd0);
        chk("reset rs2_data",   rs2_data,  32'd0);
        chk("reset dbg_rdata",  dbg_rdata, 32'd0);
        repeat (cycles) @(negedge clk);
        for (int i = 0; i < N; i++) m_mem[i] = 32'd0;
        clr_left = 31;
        m_rs1 = 32'd0;
        m_rs2 = 32'd0;
        rst_n = 1'b1;
    endtask

    function automatic logic [4:0] raddr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    task automatic random_steps(input int n);
        logic        acc;
        logic        dpend = 0;
        logic        dwe = 0;
        logic [4:0]  da = '0;
        logic [31:0] dwd = '0;
        for (int i = 0; i < n; i++) begin
            if (!dpend && $urandom_range(0, 3) == 0) begin
                dpend = 1;
                dwe   = 1'($urandom_range(0, 1));
                da    = raddr();
                dwd   = $urandom;
            end
            step(1'($urandom_range(0, 1)), raddr(),
                 1'($urandom_range(0, 2) == 0), raddr(),
                 1'($urandom_range(0, 1)), raddr(), $urandom,
                 dpend, dwe, da, dwd, acc);
            if (acc) dpend = 0;
        end
    endtask

    initial begin
        logic acc;
        drive_idle();
        @(negedge clk);
        do_reset(3);

        // Sweep length, then every entry reads zero.
        repeat (31) idle();
        for (int a = 1; a < 32; a++) begin
            step(1, 5'(a), 1, 5'(32 - a), 0, 0, 0, 0, 0, 0, 0, acc);
        end
        idle();

        // Writeback bypass to rs1, then plain read on rs2.
        step(1, 5, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, acc);
        step(0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, acc);
        idle();

        // Debug write blocked by writeback, then accepted.
        step(0, 0, 0, 0, 1, 7, 32'h11111111, 1, 1, 7, 32'hCAFEF00D, acc);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 32'hCAFEF00D, acc);
        step(1, 7, 1, 7, 0, 0, 0, 0, 0, 0, 0, acc);

        // Debug read stalled by rs2, then accepted; also bypassed debug read.
        step(0, 0, 0, 0, 1, 3, 32'h33333333, 0, 0, 0, 0, acc);
        step(0, 0, 1, 10, 0, 0, 0, 1, 0, 3, 0, acc);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, acc);
        idle();
        step(0, 0, 0, 0, 1, 4, 32'h44440000, 1, 0, 4, 0, acc);
        idle();

        // Writes to x0 are discarded and x0 never bypasses.
        step(1, 0, 0, 0, 1, 0, 32'h12345678, 0, 0, 0, 0, acc);
        step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, acc);
        idle();

        // Reset while a debug read response is in flight.
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 5, 0, acc);
        do_reset(2);
        repeat (20) idle();

        // Reset mid-sweep (entry 15 next), then full-length sweep under noise.
        do_reset(1);
        repeat (14) idle();
        do_reset(2);
        random_steps(31);
        random_steps(700);
        idle();

        chk("dbg queue drained", 32'(q_dbg.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_ctrl.md
RF_CTRL -- requirements
Module: rf_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter depth, default 5, register address width (2**depth entries, entry 0 hardwired zero).
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 rf_ready  output  1  high when the clear sweep is done and the core may issue accesses.
REQ-006 rs1_en, rs2_en  input  1 each  core read-port request, this cycle.
REQ-007 rs1_addr, rs2_addr  input  depth each  core read addresses.
REQ-008 rs1_data, rs2_data  output  XLEN each  read data, one cycle after request.
REQ-009 wb_we  input  1  writeback write enable.
REQ-010 wb_addr  input  depth  writeback destination.
REQ-011 wb_data  input  XLEN  writeback data.
REQ-012 dbg_req  input  1  debug access valid, held until accepted.
REQ-013 dbg_we  input  1  debug access is write (1) or read (0).
REQ-014 dbg_addr  input  depth  debug address.
REQ-015 dbg_wdata  input  XLEN  debug write data.
REQ-016 dbg_ready  output  1  debug access accepted this cycle (dbg_req && dbg_ready = handshake).
REQ-017 dbg_rvalid  output  1  one-cycle pulse, dbg_rdata valid.
REQ-018 dbg_rdata  output  XLEN  debug read data.

Function
REQ-019 FSM states SHALL be CLEAR and RUN; reset enters CLEAR with sweep counter = 1.
REQ-020 In CLEAR the block SHALL write 0 to address = counter each cycle, increment counter, and go to RUN after writing address 2**depth-1 (31 cycles at depth=5).
REQ-021 rf_ready SHALL be 0 in CLEAR and 1 in RUN; in CLEAR, wb_we, rs*_en and dbg_req SHALL be ignored, and dbg_ready SHALL be 0.
REQ-022 In RUN, the SRAM write port SHALL take wb_* when wb_we=1; otherwise it SHALL take an accepted debug write.
REQ-023 A debug write SHALL be accepted (dbg_ready=1) only in a RUN cycle with wb_we=0.
REQ-024 A debug read SHALL use read port 2 and SHALL be accepted only in a RUN cycle with rs2_en=0.
REQ-025 dbg_rvalid SHALL pulse exactly one cycle after debug read acceptance, with dbg_rdata valid in that cycle.
REQ-026 Read latency SHALL be exactly one cycle; a read issued with address 0 SHALL return 0.
REQ-027 Bypass: if a read at cycle N targets a nonzero address written in cycle N, the data returned at N+1 SHALL be the new write data, not the stale SRAM word.
REQ-028 The bypass SHALL apply to rs1, rs2 and debug reads alike, and SHALL never apply to address 0.
REQ-029 Writes to address 0 SHALL be discarded.
REQ-030 rs*_data SHALL hold their last value in cycles with no read issued.
REQ-031 dbg_ready SHALL be combinational from dbg_req, dbg_we, wb_we, rs2_en and state. It SHALL have no dependency on dbg_rvalid.

Reset
REQ-032 Asserting rst_n low at any time, including mid-sweep or mid-debug-read, SHALL force CLEAR, counter=1, rf_ready=0, dbg_rvalid=0, and bypass flags=0, and SHALL drop any pending debug read.
REQ-033 rs1_data, rs2_data and dbg_rdata SHALL reset to 0.
REQ-034 On release of rst_n, the sweep SHALL restart from address 1.

Structure
REQ-035 Package rf_pkg SHALL hold the defaults for XLEN and depth and the FSM state enum (CLEAR, RUN).
REQ-036 rf_ctrl SHALL instantiate one sync_sram sub-module for storage. Arbitration, sweep, bypass registers and output muxes SHALL live in rf_ctrl.

Verification
REQ-037 Reset release -> rf_ready=0 for 31 cycles, then 1. Reads of x1..x31 then return 0.
REQ-038 Same-cycle wb_we to x5 = 0xDEADBEEF with rs1_en on x5 -> rs1_data=0xDEADBEEF next cycle.
REQ-039 wb_we and debug write to x7 in the same cycle -> dbg_ready=0. Next cycle with wb_we=0 -> accepted, and x7 reads dbg_wdata.
REQ-040 Debug read of x3 with rs2_en=1 -> stalled. With rs2_en=0 -> dbg_rvalid pulse next cycle carrying the x3 value.
REQ-041 wb_we to x0 = 0x12345678, then read x0 -> 0.
REQ-042 rst_n low at sweep address 15 -> after release, rf_ready stays 0 for a full 31 cycles.
